// File: rtl/apb_reg_completer_if.sv
// APB bus bundle for the register completer: requester-driven request fields,
// completer-driven response fields.
`timescale 1ns/1ps
interface apb_reg_completer_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [addr_width-1:0] PADDR;
  logic [data_width-1:0] PWDATA;
  logic [data_width-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_reg_completer.sv
// APB completer with NUM_REGS-1 read/write words plus a read-only transfer counter
// in the top word; every access is stretched by WAIT_STATES PREADY-low cycles.
`timescale 1ns/1ps
module apb_reg_completer #(
  parameter int addr_width  = 32,
  parameter int data_width  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_reg_completer_if.slave    apb,
  output logic [data_width-1:0] ctrl_o
);

  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int XFER_IDX = NUM_REGS - 1;

  localparam logic [IDX_W:0]        REG_LIMIT = (IDX_W + 1)'(NUM_REGS);
  localparam logic [IDX_W-1:0]      XFER_SEL  = IDX_W'(XFER_IDX);
  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [data_width-1:0] DATA_ONE  = data_width'(1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    capture;

  logic [addr_width-1:0]   addr_reg;
  logic                    write_reg;
  logic [data_width-1:0]   wdata_reg;

  logic [data_width-1:0]   regs_reg [NUM_REGS-1];
  logic [data_width-1:0]   xfer_cnt_reg;

  logic [IDX_W-1:0]        idx;
  logic                    is_xfer;
  logic                    err;
  logic [data_width-1:0]   rd_word;

  logic                    pready;
  logic                    pslverr;
  logic [data_width-1:0]   prdata;
  logic                    complete;
  logic                    wr_en;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        // PSEL with PENABLE already high is an illegal entry and is ignored.
        if (apb.PSEL && !apb.PENABLE) begin
          state_next = ACCESS;
          cnt_next   = CNT_LOAD;
          capture    = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_next = IDLE;
        end else if (apb.PENABLE) begin
          if (cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pready   = (state_reg == ACCESS) && (cnt_reg == '0);
    pslverr  = pready && err;
    prdata   = (pready && !write_reg && !err) ? rd_word : '0;
    complete = pready && apb.PSEL && apb.PENABLE;
    wr_en    = complete && write_reg && !err;
  end

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;
  assign apb.PRDATA  = prdata;

  // Request fields are frozen at SETUP so bus changes during ACCESS have no effect.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
    end else if (capture) begin
      addr_reg  <= apb.PADDR;
      write_reg <= apb.PWRITE;
      wdata_reg <= apb.PWDATA;
    end
  end

  // ---------------- address decode and error ----------------
  always_comb begin
    idx     = addr_reg[IDX_W+1:2];
    is_xfer = (idx == XFER_SEL);
    err     = ({1'b0, idx} >= REG_LIMIT)
           || (addr_reg[1:0] != 2'b00)
           || (addr_reg[addr_width-1:IDX_W+2] != '0)
           || (write_reg && is_xfer);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_word = regs_reg[i];
      end
    end
    if (is_xfer) begin
      rd_word = xfer_cnt_reg;
    end
  end

  // ---------------- register file ----------------
  generate
    for (genvar gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
      localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
      always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
          regs_reg[gi] <= '0;
        end else if (wr_en && (idx == GI_IDX)) begin
          regs_reg[gi] <= wdata_reg;
        end
      end
    end
  endgenerate

  // Counts only clean completions; a read of the counter sees the pre-increment value.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      xfer_cnt_reg <= '0;
    end else if (complete && !err) begin
      xfer_cnt_reg <= xfer_cnt_reg + DATA_ONE;
    end
  end

  assign ctrl_o = regs_reg[0];

endmodule

// File: tb/tb_apb_reg_completer.sv
// Randomized APB transfers against a transaction-level register-map model.
`timescale 1ns/1ps
module tb_apb_reg_completer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int WS = 2;

  logic          PCLK   = 1'b0;
  logic          PRESET = 1'b0;
  logic [DW-1:0] ctrl_o;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_xfer;

  apb_reg_completer_if #(.addr_width(AW), .data_width(DW)) bus ();

  apb_reg_completer #(
    .addr_width (AW),
    .data_width (DW),
    .NUM_REGS   (NR),
    .WAIT_STATES(WS)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .apb   (bus),
    .ctrl_o(ctrl_o)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Byte address must be word aligned and fall inside the map; the last word is read-only.
  function automatic bit m_err(input logic [AW-1:0] a, input bit wr);
    if (a % 4 != 0) return 1'b1;
    if (a / 4 >= NR) return 1'b1;
    if (wr && (a / 4 == NR - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_xfer = '0;
  endtask

  task automatic scramble_bus();
    bus.PADDR  = $urandom;
    bus.PWDATA = $urandom;
    bus.PWRITE = 1'($urandom_range(0, 1));
  endtask

  task automatic apb_xfer(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                          input bit scramble);
    bit            e;
    int            w;
    int            waits;
    logic [DW-1:0] exp_rd;
    e      = m_err(a, wr);
    w      = int'(a / 4);
    exp_rd = '0;
    if (!wr && !e) exp_rd = (w == NR - 1) ? m_xfer : m_regs[w];
    @(negedge PCLK);
    chk("ctrl_o", ctrl_o, m_regs[0]);
    chk("setup_pready", DW'(bus.PREADY), '0);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = wd;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    waits = 0;
    while (bus.PREADY !== 1'b1 && waits < 16) begin
      if (scramble) scramble_bus();
      @(negedge PCLK);
      waits++;
    end
    chk("wait_cycles", DW'(waits), DW'(WS));
    chk("pslverr", DW'(bus.PSLVERR), DW'(e));
    chk("prdata", bus.PRDATA, exp_rd);
    $display("xfer %s addr=%h wdata=%h prdata=%h pslverr=%0b waits=%0d",
             wr ? "WR" : "RD", a, wd, bus.PRDATA, bus.PSLVERR, waits);
    if (!e) begin
      if (wr) m_regs[w] = wd;
      m_xfer = m_xfer + 1;
    end
  endtask

  task automatic go_idle();
    @(negedge PCLK);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic abort_xfer(input logic [AW-1:0] a, input logic [DW-1:0] wd);
    @(negedge PCLK);
    chk("ctrl_o", ctrl_o, m_regs[0]);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = a;
    bus.PWDATA  = wd;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    chk("abort_pready0", DW'(bus.PREADY), '0);
    @(negedge PCLK);
    chk("abort_pready1", DW'(bus.PREADY), '0);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_idle_pready", DW'(bus.PREADY), '0);
    $display("abort addr=%h wdata=%h", a, wd);
  endtask

  task automatic violation();
    @(negedge PCLK);
    chk("ctrl_o", ctrl_o, m_regs[0]);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = '0;
    bus.PWDATA  = $urandom;
    repeat (2) begin
      @(negedge PCLK);
      chk("viol_pready", DW'(bus.PREADY), '0);
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    $display("violation PSEL+PENABLE from idle wdata=%h", bus.PWDATA);
  endtask

  task automatic reset_mid_xfer();
    @(negedge PCLK);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = '0;
    bus.PWDATA  = 32'hFFFF_FFFF;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #2 PRESET = 1'b0;
    #1;
    chk("rst_ctrl_o", ctrl_o, '0);
    chk("rst_pready", DW'(bus.PREADY), '0);
    chk("rst_pslverr", DW'(bus.PSLVERR), '0);
    chk("rst_prdata", bus.PRDATA, '0);
    model_reset();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge PCLK);
    #2 PRESET = 1'b1;
    $display("reset asserted mid-transfer and released");
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    logic [AW-1:0] word;
    word = AW'($urandom_range(0, NR - 1)) * 4;
    case ($urandom_range(0, 9))
      6:       a = word + AW'($urandom_range(1, 3));
      7:       a = 32'h20 + AW'($urandom_range(0, 7)) * 4;
      8:       a = (AW'($urandom_range(1, 255)) << 8) | word;
      default: a = word;
    endcase
    return a;
  endfunction

  initial begin
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    model_reset();

    repeat (2) @(negedge PCLK);
    chk("reset_pready", DW'(bus.PREADY), '0);
    chk("reset_pslverr", DW'(bus.PSLVERR), '0);
    chk("reset_prdata", bus.PRDATA, '0);
    chk("reset_ctrl_o", ctrl_o, '0);
    @(posedge PCLK);
    #2 PRESET = 1'b1;

    // basic write then read-back and counter read
    apb_xfer(32'h04, 1'b1, 32'hA5A5_0001, 1'b0);
    apb_xfer(32'h04, 1'b0, '0, 1'b0);
    apb_xfer(32'h1C, 1'b0, '0, 1'b0);
    // errors: counter write, out-of-range read, misaligned write
    apb_xfer(32'h1C, 1'b1, 32'hDEAD_BEEF, 1'b0);
    apb_xfer(32'h20, 1'b0, '0, 1'b0);
    apb_xfer(32'h05, 1'b1, 32'h0000_1234, 1'b0);
    apb_xfer(32'h04, 1'b0, '0, 1'b0);
    apb_xfer(32'h1C, 1'b0, '0, 1'b0);
    // abort, then a normal transfer
    apb_xfer(32'h00, 1'b1, 32'h0000_00C3, 1'b0);
    abort_xfer(32'h00, 32'h1111_2222);
    apb_xfer(32'h1C, 1'b0, '0, 1'b0);
    apb_xfer(32'h08, 1'b1, 32'h0BAD_F00D, 1'b1);
    // protocol violation leaves everything untouched
    violation();
    apb_xfer(32'h00, 1'b0, '0, 1'b0);
    // reset mid-transfer
    reset_mid_xfer();
    apb_xfer(32'h00, 1'b0, '0, 1'b0);
    apb_xfer(32'h04, 1'b0, '0, 1'b0);
    apb_xfer(32'h1C, 1'b0, '0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        abort_xfer(AW'($urandom_range(0, NR - 2)) * 4, $urandom);
      end else begin
        apb_xfer(rand_addr(), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < NR; i++) apb_xfer(AW'(i) * 4, 1'b0, '0, 1'b0);

    // counter wrap from all-ones
    go_idle();
    @(negedge PCLK);
    force dut.xfer_cnt_reg = 32'hFFFF_FFFF;
    #1 release dut.xfer_cnt_reg;
    m_xfer = 32'hFFFF_FFFF;
    apb_xfer(32'h1C, 1'b0, '0, 1'b0);
    apb_xfer(32'h00, 1'b0, '0, 1'b0);
    apb_xfer(32'h1C, 1'b0, '0, 1'b0);
    go_idle();
    @(negedge PCLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
